square_judge_ms: RTL and testbench
==================================

# square_judge_ms

Parametrised square-wave classifier for the demodulation front end. It watches a stream of signed samples qualified by `din_valid` over a fixed window of valid samples. Edges are steps whose magnitude meets a run-time threshold; glitches are rejected by minimum-spacing rules. At window end it reports edge count, minimum and maximum opposite-edge spacing, and a square/not-square verdict, with a start/busy/done handshake.

## Interface
- `DW`, 18: input sample width, two's complement.
- `CW`, 16: width of the window counter, timestamps, edge count and width outputs.
- `WIN`, 6000: measurement window in valid samples; must satisfy 1 ≤ WIN < 2^CW.
- `MIN_GAP`, 25: same-polarity spacing (samples) an edge must exceed to be valid.
- `MIN_OPP`, 100: opposite-polarity spacing a width sample must exceed to be recorded.
- `EDGE_NUM`, 30: square verdict threshold on edge count.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: one-cycle request to begin or restart a measurement.
- `din`, in, DW: signed sample.
- `din_valid`, in, 1: `din` qualifier.
- `thresh`, in, DW: unsigned edge magnitude threshold, latched on `start`.
- `busy`, out, 1: high while in ARM or MEAS.
- `done`, out, 1: one-cycle result pulse.
- `is_square`, out, 1: high when `edge_cnt` > EDGE_NUM.
- `edge_cnt`, out, CW: valid edges in the last window; saturates at all ones.
- `min_width`, out, CW: smallest recorded width; all ones if no width was recorded.
- `max_width`, out, CW: largest recorded width; 0 if no width was recorded.

## Operation
**FSM states:** IDLE → ARM → MEAS → DONE → IDLE.
- `start` in any state clears internal accumulators, latches `thresh` and enters ARM.
  - A `start` while busy aborts the current window: no `done`, outputs keep their previous values.
- **ARM:** the first valid sample becomes the reference `prev`. No edge is evaluated. Move to MEAS.
- **MEAS:** each valid sample increments sample index `k` (1..WIN) and computes `diff = din − prev`, signed and DW+1 bits, no overflow. `prev` then takes `din`.
- **Raw edge:** `diff ≠ 0` and `|diff| ≥ thresh_l`.
  - Rising if `diff > 0`, falling if `diff < 0`.
  - `thresh_l = 0` therefore means any nonzero step is an edge.
- **Valid edge:** a raw edge whose distance `k` − (last raw edge of the same polarity) exceeds MIN_GAP.
  - The first edge of each polarity is always valid.
  - Every raw edge updates its polarity's raw timestamp, valid or not.
- Each valid edge increments `edge_cnt`, saturating, and updates its polarity's valid timestamp.
- **Width sample:** if a valid timestamp of the opposite polarity exists, `w = k − that timestamp`.
  - `w` is recorded only if `w > MIN_OPP`.
  - A recorded `w` updates the running min and max.
- **Window end:** after sample WIN is fully processed, move to DONE.
  - Load `edge_cnt`, `min_width`, `max_width` and `is_square` into the output registers.
  - Pulse `done`, then go to IDLE.
- Outputs hold their values until the next DONE or `rst`.
- **`rst`:**
  - Go to IDLE.
  - Outputs reset: `busy = 0`, `done = 0`, `is_square = 0`, `edge_cnt = 0`, `min_width` all ones, `max_width = 0`.
  - Accumulators cleared; any window in progress is discarded.

## Timing
- `start` sampled high in cycle N → `busy = 1` from N+1.
- Internal pipeline: stage 1 registers `diff`; stage 2 classifies edges and updates timestamps, counts and min/max.
- `done` is high exactly 3 cycles after the cycle carrying the WIN-th valid sample in MEAS. Result outputs are valid in that same cycle.
- `busy` drops in the `done` cycle.
- `din_valid` gaps stall `k` and classification only; latency is counted from the last valid sample.
- `start` in the `done` cycle: `done` still pulses, and `busy` is high the next cycle.
- `start` and `rst` together: `rst` wins.
- The same cycle can carry a width sample and the first update of min and max: both take `w`.
- `edge_cnt` saturation does not stop width updates.

## Test plan
Settings: DW=18, CW=16, WIN=64, MIN_GAP=2, MIN_OPP=4, EDGE_NUM=6, `thresh`=1000.
- **Square wave:** ±5000, 8 samples per level, `din_valid` continuous, reference sample at the start of a +5000 level → `edge_cnt = 8`, `min_width = max_width = 8`, `is_square = 1`, `done` 3 cycles after the 64th valid sample.
- **Staircase:** +200 per sample → `edge_cnt = 0`, `min_width = 0xFFFF`, `max_width = 0`, `is_square = 0`.
- **MIN_GAP rejection:** two +1500 steps at k=10 and k=12, flat otherwise → `edge_cnt = 1`, no width recorded.
- **Gapped valid:** same stimulus as the square wave, `din_valid` toggling every cycle → identical results; `done` 3 cycles after the 64th valid sample.
- **Restart:** `start` re-asserted at valid sample 30 → no `done` for the aborted window; `busy` stays 1; results reflect only the new 64 samples.
- **Reset mid-window:** `rst` in MEAS → next cycle `busy = 0` and all outputs at reset values; no `done` ever follows.

Source files
------------

// File: rtl/square_judge_ms.sv
// Square-wave classifier: counts thresholded edges over a window of valid samples,
// rejects glitches by spacing rules and reports edge count, width range and a verdict.
module square_judge_ms #(
  parameter int DW       = 18,
  parameter int CW       = 16,
  parameter int WIN      = 6000,
  parameter int MIN_GAP  = 25,
  parameter int MIN_OPP  = 100,
  parameter int EDGE_NUM = 30
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  input  logic [DW-1:0] thresh,
  output logic          busy,
  output logic          done,
  output logic          is_square,
  output logic [CW-1:0] edge_cnt,
  output logic [CW-1:0] min_width,
  output logic [CW-1:0] max_width
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_t;

  localparam logic [CW-1:0] WIN_C   = CW'(WIN);
  localparam logic [CW-1:0] GAP_C   = CW'(MIN_GAP);
  localparam logic [CW-1:0] OPP_C   = CW'(MIN_OPP);
  localparam logic [CW-1:0] EDGE_C  = CW'(EDGE_NUM);
  localparam logic [CW-1:0] ONE_C   = 1;
  localparam logic [DW:0]   ONE_D   = 1;

  state_t        state;
  logic [DW-1:0] thresh_l;
  logic [DW-1:0] prev;
  logic [CW-1:0] k;

  logic          s1_valid;
  logic          s1_last;
  logic [DW:0]   s1_diff;
  logic [CW-1:0] s1_k;
  logic          s2_last;

  logic          have_raw_r, have_raw_f, have_val_r, have_val_f;
  logic [CW-1:0] raw_ts_r, raw_ts_f, val_ts_r, val_ts_f;
  logic [CW-1:0] edge_acc, min_acc, max_acc;

  logic [CW-1:0] k_next;
  logic [DW:0]   mag;
  logic          rising, raw_edge, valid_edge, rec_width;
  logic          same_have, opp_have;
  logic [CW-1:0] same_ts, opp_ts, width;

  // Stage-2 classification of the registered step
  always_comb begin
    k_next     = k + ONE_C;
    mag        = s1_diff[DW] ? (~s1_diff + ONE_D) : s1_diff;
    rising     = ~s1_diff[DW];
    raw_edge   = s1_valid && (s1_diff != '0) && (mag >= {1'b0, thresh_l});
    same_have  = rising ? have_raw_r : have_raw_f;
    same_ts    = rising ? raw_ts_r : raw_ts_f;
    opp_have   = rising ? have_val_f : have_val_r;
    opp_ts     = rising ? val_ts_f : val_ts_r;
    valid_edge = raw_edge && (!same_have || ((s1_k - same_ts) > GAP_C));
    width      = s1_k - opp_ts;
    rec_width  = valid_edge && opp_have && (width > OPP_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      is_square  <= 1'b0;
      edge_cnt   <= '0;
      min_width  <= '1;
      max_width  <= '0;
      thresh_l   <= '0;
      prev       <= '0;
      k          <= '0;
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s1_diff    <= '0;
      s1_k       <= '0;
      s2_last    <= 1'b0;
      have_raw_r <= 1'b0;
      have_raw_f <= 1'b0;
      have_val_r <= 1'b0;
      have_val_f <= 1'b0;
      raw_ts_r   <= '0;
      raw_ts_f   <= '0;
      val_ts_r   <= '0;
      val_ts_f   <= '0;
      edge_acc   <= '0;
      min_acc    <= '1;
      max_acc    <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // Restart discards any in-flight window but leaves published results alone
        state      <= ARM;
        busy       <= 1'b1;
        thresh_l   <= thresh;
        k          <= '0;
        s1_valid   <= 1'b0;
        s1_last    <= 1'b0;
        s2_last    <= 1'b0;
        have_raw_r <= 1'b0;
        have_raw_f <= 1'b0;
        have_val_r <= 1'b0;
        have_val_f <= 1'b0;
        edge_acc   <= '0;
        min_acc    <= '1;
        max_acc    <= '0;
      end else begin
        case (state)
          IDLE: ;
          ARM: begin
            if (din_valid) begin
              prev  <= din;
              state <= MEAS;
            end
          end
          MEAS: begin
            if (din_valid && (k != WIN_C)) begin
              k        <= k_next;
              s1_diff  <= {din[DW-1], din} - {prev[DW-1], prev};
              prev     <= din;
              s1_valid <= 1'b1;
              s1_k     <= k_next;
              s1_last  <= (k_next == WIN_C);
            end else begin
              s1_valid <= 1'b0;
              s1_last  <= 1'b0;
            end
            s2_last <= s1_last;
            if (raw_edge) begin
              if (rising) begin
                have_raw_r <= 1'b1;
                raw_ts_r   <= s1_k;
              end else begin
                have_raw_f <= 1'b1;
                raw_ts_f   <= s1_k;
              end
            end
            if (valid_edge) begin
              if (edge_acc != '1) edge_acc <= edge_acc + ONE_C;
              if (rising) begin
                have_val_r <= 1'b1;
                val_ts_r   <= s1_k;
              end else begin
                have_val_f <= 1'b1;
                val_ts_f   <= s1_k;
              end
            end
            if (rec_width) begin
              if (width < min_acc) min_acc <= width;
              if (width > max_acc) max_acc <= width;
            end
            if (s2_last) begin
              edge_cnt  <= edge_acc;
              min_width <= min_acc;
              max_width <= max_acc;
              is_square <= (edge_acc > EDGE_C);
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= DONE;
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_square_judge_ms.sv
// Directed bench for square_judge_ms with a short window; expected values are hand-derived.
module tb_square_judge_ms;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [17:0] din;
  logic        din_valid;
  logic [17:0] thresh;
  logic        busy, done, is_square;
  logic [15:0] edge_cnt, min_width, max_width;

  int errors = 0;
  int checks = 0;
  bit done_seen;

  square_judge_ms #(
    .DW(18), .CW(16), .WIN(64), .MIN_GAP(2), .MIN_OPP(4), .EDGE_NUM(6)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
    .thresh(thresh), .busy(busy), .done(done), .is_square(is_square),
    .edge_cnt(edge_cnt), .min_width(min_width), .max_width(max_width)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the capturing edge
  task automatic applyStimulus(input int d, input logic v, input logic s);
    din       = d[17:0];
    din_valid = v;
    start     = s;
    @(posedge clk);
    #1;
    if (done) done_seen = 1'b1;
    start     = 1'b0;
    din_valid = 1'b0;
  endtask

  function automatic int sampleVal(input int pattern, input int i);
    case (pattern)
      0:       return (((i / 8) % 2) == 0) ? 5000 : -5000;
      1:       return i * 200;
      default: return (i < 10) ? 0 : ((i < 12) ? 1500 : 3000);
    endcase
  endfunction

  task automatic startWindow(input string tag);
    done_seen = 1'b0;
    applyStimulus(0, 1'b0, 1'b1);
    checkOutput({tag, "_busy_start"}, busy, 1);
  endtask

  task automatic feedSamples(input int pattern, input bit gapped, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      if (gapped) applyStimulus(-20000, 1'b0, 1'b0);
      applyStimulus(sampleVal(pattern, i), 1'b1, 1'b0);
    end
  endtask

  task automatic finishWindow(input string tag, input int cnt, input int mn, input int mx, input int sq);
    checkOutput({tag, "_no_early_done"}, done_seen, 0);
    checkOutput({tag, "_done_lat1"}, done, 0);
    applyStimulus(0, 1'b0, 1'b0);
    checkOutput({tag, "_done_lat2"}, done, 0);
    checkOutput({tag, "_busy_lat2"}, busy, 1);
    applyStimulus(0, 1'b0, 1'b0);
    checkOutput({tag, "_done_lat3"}, done, 1);
    checkOutput({tag, "_busy_done"}, busy, 0);
    checkOutput({tag, "_edge_cnt"}, edge_cnt, cnt);
    checkOutput({tag, "_min_width"}, min_width, mn);
    checkOutput({tag, "_max_width"}, max_width, mx);
    checkOutput({tag, "_is_square"}, is_square, sq);
    applyStimulus(0, 1'b0, 1'b0);
    checkOutput({tag, "_done_pulse"}, done, 0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_is_square"}, is_square, 0);
    checkOutput({tag, "_edge_cnt"}, edge_cnt, 0);
    checkOutput({tag, "_min_width"}, min_width, 16'hFFFF);
    checkOutput({tag, "_max_width"}, max_width, 0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    thresh    = 18'd1000;
    done_seen = 1'b0;
    applyStimulus(0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 1'b0);
    rst = 1'b0;
    checkResetValues("reset");

    $display("[TB] square wave");
    startWindow("square");
    feedSamples(0, 1'b0, 0, 64);
    finishWindow("square", 8, 8, 8, 1);

    $display("[TB] staircase");
    startWindow("stair");
    feedSamples(1, 1'b0, 0, 64);
    finishWindow("stair", 0, 16'hFFFF, 0, 0);

    $display("[TB] min gap rejection");
    startWindow("gap");
    feedSamples(2, 1'b0, 0, 64);
    finishWindow("gap", 1, 16'hFFFF, 0, 0);

    $display("[TB] gapped valid");
    startWindow("gapped");
    feedSamples(0, 1'b1, 0, 64);
    finishWindow("gapped", 8, 8, 8, 1);

    $display("[TB] restart");
    startWindow("abort");
    feedSamples(0, 1'b0, 0, 30);
    startWindow("restart");
    feedSamples(0, 1'b0, 0, 64);
    finishWindow("restart", 8, 8, 8, 1);

    $display("[TB] reset mid-window");
    startWindow("rstmid");
    feedSamples(0, 1'b0, 0, 20);
    rst = 1'b1;
    applyStimulus(5000, 1'b1, 1'b0);
    rst = 1'b0;
    checkResetValues("rstmid");
    done_seen = 1'b0;
    feedSamples(0, 1'b0, 0, 70);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1'b0, 1'b0);
    checkOutput("rstmid_no_done", done_seen, 0);
    checkOutput("rstmid_busy_after", busy, 0);
    checkOutput("rstmid_edge_cnt_after", edge_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
